sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Single-clock synchronous FIFO with first-word-fall-through output.
//  Buffers DATA_WIDTH-bit words between a producer (valid/ready source) and an AXI-Stream
//  master interface. Head word is always visible on data_out while not empty.
//  Status flags feed ready/valid directly: ready = ~full, tvalid = ~empty.
// PARAMETERS
//  DATA_WIDTH  64  width of each stored word in bits (>=1)
//  DEPTH        8  number of storage entries (>=2; any integer, need not be a power of 2)
// PORTS
//  clk        in   1           clock; all state updates on rising edge
//  rst        in   1           synchronous, active-high reset
//  w_enable   in   1           write request; data_in stored at rising edge if accepted
//  r_enable   in   1           read request; pops head word at rising edge if accepted
//  data_in    in   DATA_WIDTH  write data
//  data_out   out  DATA_WIDTH  current head word (combinational from storage, FWFT)
//  full       out  1           1 when DEPTH words stored
//  empty      out  1           1 when 0 words stored
// BEHAVIOUR
//  - Reset (rst=1 at rising edge): write ptr=0, read ptr=0, count=0 -> empty=1, full=0.
//    Storage contents are not cleared; data_out forced to 0 while empty.
//  - rst has priority over w_enable/r_enable in the same cycle; reset mid-stream drops all data.
//  - Internal count 0..DEPTH (width $clog2(DEPTH+1)); empty = (count==0), full = (count==DEPTH).
//    Both flags derived from registered state, so they change only after a clock edge.
//  - Write accepted iff w_enable && !full (full as sampled before the edge):
//    mem[wr_ptr] <= data_in; wr_ptr advances.
//  - Read accepted iff r_enable && !empty: rd_ptr advances; popped word is the value
//    on data_out during that cycle (zero read latency).
//  - Pointer wrap: ptr == DEPTH-1 -> 0 on advance (explicit compare, not power-of-2 masking).
//  - Count update: write only +1; read only -1; both accepted -> unchanged; neither -> unchanged.
//  - Write while full: ignored (no storage change, no pointer move, no error flag),
//    even if r_enable=1 in the same cycle; the read still proceeds.
//  - Read while empty: ignored, even if w_enable=1 in the same cycle; the write still
//    proceeds, and the new word appears on data_out the next cycle.
//  - Write into empty FIFO: empty deasserts and data_out = written word one cycle after the edge.
//  - data_out = mem[rd_ptr] when !empty, else 0. No registered output stage.
//  - Order strictly preserved; no word duplicated or lost except writes while full.
// TESTING
//  1 Reset: assert rst 2 cycles -> empty=1, full=0, data_out=0; deassert -> unchanged.
//  2 Fill/drain: write 1..8 -> full=1 after 8th edge; 9th write (99) ignored;
//    read 8 times -> data_out 1,2,...,8 in order; empty=1 after last read.
//  3 Simultaneous R/W with count=3 (10,11,12): write 13 + read -> pops 10, count stays 3,
//    head becomes 11; repeat 20 cycles crossing pointer wrap -> order preserved.
//  4 Boundaries: empty + w_enable=r_enable=1 with 5 -> write only, data_out=5 next cycle;
//    full + both asserted -> read pops head, write dropped, full=0 afterwards.
//  5 Read on empty (r_enable=1, no writes, 3 cycles) -> empty stays 1, no pointer change;
//    subsequent write 7 then read -> data_out=7.
//  6 Reset mid-operation with 4 words stored -> empty=1 next cycle; writing 42 then reading
//    returns 42 (stale words gone).

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output: the head word is visible
// on data_out whenever the FIFO holds data, and reads pop it with zero latency.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_enable,
    input  logic                  r_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  wr_accept;
    logic                  rd_accept;
    logic [PTR_W-1:0]      wr_ptr_nxt;
    logic [PTR_W-1:0]      rd_ptr_nxt;
    logic [CNT_W-1:0]      count_nxt;

    // Acceptance uses the flags as held before the edge; pointers wrap by compare.
    always_comb begin
        wr_accept  = w_enable && !full;
        rd_accept  = r_enable && !empty;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (wr_accept) begin
            wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (rd_accept) begin
            rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        end
        if (wr_accept && !rd_accept) begin
            count_nxt = count + CNT_W'(1);
        end else if (rd_accept && !wr_accept) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Flags are registered from the next count so they track count exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            empty  <= (count_nxt == '0);
            full   <= (count_nxt == CNT_W'(DEPTH));
        end
    end

    // Storage is never cleared; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    assign data_out = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios followed by random traffic, all checked
// against a queue-based model of FIFO contents.
module tb_sync_fifo;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 8;

    logic          clk;
    logic          rst;
    logic          w_enable;
    logic          r_enable;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model_q[$];

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .w_enable (w_enable),
        .r_enable (r_enable),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [DW-1:0] exp_dout;
        exp_dout = (model_q.size() != 0) ? model_q[0] : '0;
        chk({tag, ".data_out"}, data_out, exp_dout);
        chk({tag, ".full"}, DW'(full), DW'(model_q.size() == DEPTH));
        chk({tag, ".empty"}, DW'(empty), DW'(model_q.size() == 0));
    endtask

    // One clock: drive at negedge, check pre-edge outputs, update model, return at negedge.
    task automatic cyc(input logic r, input logic we, input logic re, input logic [DW-1:0] din,
                       input string tag);
        logic wacc;
        logic racc;
        rst = r; w_enable = we; r_enable = re; data_in = din;
        #1;
        chk_model(tag);
        @(posedge clk);
        if (r) begin
            model_q.delete();
        end else begin
            wacc = we && (model_q.size() < DEPTH);
            racc = re && (model_q.size() > 0);
            if (racc) void'(model_q.pop_front());
            if (wacc) model_q.push_back(din);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; w_enable = 1'b0; r_enable = 1'b0; data_in = '0;
        // Reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.empty", DW'(empty), DW'(1));
        chk("reset.full", DW'(full), DW'(0));
        chk("reset.data_out", data_out, '0);
        cyc(1'b0, 1'b0, 1'b0, '0, "post_reset");
        chk("post_reset.empty", DW'(empty), DW'(1));

        // Fill and drain
        for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, 1'b0, DW'(i), "fill");
        chk("fill.full", DW'(full), DW'(1));
        cyc(1'b0, 1'b1, 1'b0, DW'(99), "overfill");
        chk("overfill.full", DW'(full), DW'(1));
        for (int i = 1; i <= 8; i++) begin
            chk("drain.order", data_out, DW'(i));
            cyc(1'b0, 1'b0, 1'b1, '0, "drain");
        end
        chk("drain.empty", DW'(empty), DW'(1));

        // Simultaneous read/write at count 3, crossing pointer wrap
        for (int i = 10; i <= 12; i++) cyc(1'b0, 1'b1, 1'b0, DW'(i), "pre_rw");
        for (int k = 0; k < 20; k++) begin
            chk("rw.head", data_out, DW'(10 + k));
            cyc(1'b0, 1'b1, 1'b1, DW'(13 + k), "rw");
        end
        chk("rw.count", DW'(model_q.size()), DW'(3));
        chk("rw.head_after", data_out, DW'(30));
        while (model_q.size() != 0) cyc(1'b0, 1'b0, 1'b1, '0, "rw_drain");

        // Both asserted on empty: write only
        cyc(1'b0, 1'b1, 1'b1, DW'(5), "empty_both");
        chk("empty_both.data_out", data_out, DW'(5));
        for (int i = 6; i <= 12; i++) cyc(1'b0, 1'b1, 1'b0, DW'(i), "refill");
        chk("refill.full", DW'(full), DW'(1));
        // Both asserted on full: read pops, write dropped
        cyc(1'b0, 1'b1, 1'b1, DW'(77), "full_both");
        chk("full_both.full", DW'(full), DW'(0));
        chk("full_both.head", data_out, DW'(6));
        for (int i = 6; i <= 12; i++) begin
            chk("full_both.order", data_out, DW'(i));
            cyc(1'b0, 1'b0, 1'b1, '0, "full_both_drain");
        end
        chk("full_both.empty", DW'(empty), DW'(1));

        // Read on empty is ignored
        repeat (3) cyc(1'b0, 1'b0, 1'b1, '0, "read_empty");
        chk("read_empty.empty", DW'(empty), DW'(1));
        cyc(1'b0, 1'b1, 1'b0, DW'(7), "write7");
        chk("write7.data_out", data_out, DW'(7));
        cyc(1'b0, 1'b0, 1'b1, '0, "read7");
        chk("read7.empty", DW'(empty), DW'(1));

        // Reset mid-operation drops stored words
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, DW'(100 + i), "pre_rst");
        cyc(1'b1, 1'b1, 1'b1, DW'(55), "mid_rst");
        chk("mid_rst.empty", DW'(empty), DW'(1));
        cyc(1'b0, 1'b1, 1'b0, DW'(42), "write42");
        chk("write42.data_out", data_out, DW'(42));
        cyc(1'b0, 1'b0, 1'b1, '0, "read42");
        chk("read42.empty", DW'(empty), DW'(1));

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            logic [DW-1:0] rd;
            rd = {$urandom, $urandom};
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
                ($urandom_range(0, 99) < 50), rd, "random");
        end
        chk_model("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
